ram_access_master: RTL and testbench
====================================

// Module: ram_access_master
// PURPOSE
//   Initiator side of the Ram read/write bus. Accepts one load/store request at a time from the
//   pipeline memory stage, drives a one-cycle request onto the Ram bus, waits for the Ram ready
//   pulse and returns zero/sign-extended load data or store completion. It sits between the memory
//   stage and the BusMatrix and never issues a read and a write in the same cycle.
// PARAMETERS
//   ADDR_W   64   width of request and Ram addresses
//   DATA_W   64   width of request and Ram data
//   TIMEOUT  255  max cycles in a WAIT state before an error response (1..65535)
// PORTS
//   ACLK           in   1       clock, all flops on rising edge
//   ARESET         in   1       asynchronous reset, active-high
//   ReqValid       in   1       request present
//   ReqReady       out  1       request accepted when ReqValid && ReqReady
//   ReqWrite       in   1       1 = store, 0 = load
//   ReqAddr        in   ADDR_W  byte address; 0 is illegal on this bus
//   ReqWData       in   DATA_W  store data, valid bytes in low lanes
//   ReqSize        in   2       0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B
//   ReqSigned      in   1       loads: 1 = sign-extend, 0 = zero-extend
//   RspValid       out  1       one-cycle response pulse
//   RspErr         out  1       valid with RspValid: 1 = zero address or timeout
//   RspRData       out  DATA_W  load result, valid with RspValid (0 for stores/errors)
//   RamWriteAddr   out  ADDR_W  write request address; nonzero = write request
//   RamWriteData   out  DATA_W  write data
//   RamWriteStrb   out  4       size code: 4'h1 1B, 4'h2 2B, 4'h4 4B, 4'h8 8B
//   RamReadAddr    out  ADDR_W  read request address; nonzero = read request
//   RamReadData    in   DATA_W  read data, valid with RamReadReady
//   RamReadReady   in   1       one-cycle read completion pulse
//   RamWriteReady  in   1       one-cycle write completion pulse
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 except ReqReady=1; timeout counter and request regs 0.
//   All outputs registered except ReqReady = (state == IDLE).
//   States: IDLE, ISSUE_RD, ISSUE_WR, WAIT_RD, WAIT_WR, RESP.
//   IDLE: on accept latch Write/Addr/WData/Size/Signed.
//     ReqAddr == 0 -> RESP with RspErr=1, no Ram traffic.
//     else load -> ISSUE_RD, store -> ISSUE_WR.
//   ISSUE_RD (1 cycle): RamReadAddr = addr; RamWrite* = 0 -> WAIT_RD.
//   ISSUE_WR (1 cycle): RamWriteAddr = addr; RamWriteStrb = size code;
//     RamWriteData = WData masked to size, upper bytes 0 -> WAIT_WR.
//   Request fields return to 0 on the cycle after ISSUE. The Ram restarts on any nonzero
//     address, so no address is held for more than one cycle.
//   WAIT_RD: RamReadReady=1 -> capture RamReadData[8*bytes-1:0], extend per Signed -> RESP.
//   WAIT_WR: RamWriteReady=1 -> RESP.
//   WAIT_*: counter increments each cycle. When count == TIMEOUT with no ready -> RESP,
//     RspErr=1, RspRData=0. Counter clears on leaving WAIT.
//   Only the ready matching the current WAIT state counts. The other ready, and any ready
//     seen in IDLE, ISSUE or RESP, is ignored.
//   Ready in the same cycle the counter reaches TIMEOUT: ready wins, RspErr=0.
//   RESP (1 cycle): RspValid=1 with RspErr/RspRData -> IDLE. New request accepted the next cycle.
//   Size 3 load: full 64 bits, no extension. Stores: RspRData=0.
//   Reset mid-operation: state, counter and outputs return to reset values. The bench must
//     reset the Ram too; a response already in flight is never returned.
// TESTING
//   load Addr=0x80000010 Size=0 Signed=1, Ram returns 0x...00F0
//     -> one RamReadAddr pulse, RspRData=0xFFFFFFFFFFFFFFF0, RspErr=0.
//   store Addr=0x80000020 Size=1 WData=0x1234_ABCD
//     -> one-cycle RamWriteAddr=0x80000020, Strb=4'h2, Data=0xABCD;
//     RspValid after RamWriteReady.
//   load Size=2 Signed=0, RamReadData=0xFFFF_FFFF_8000_0001 -> RspRData=0x0000_0000_8000_0001.
//   ReqAddr=0 -> RspValid one cycle after accept, RspErr=1, Ram outputs stay 0.
//   TIMEOUT=8, no ready -> RspErr=1 exactly 8 WAIT cycles after ISSUE; ReqReady back next cycle.
//   Stray RamWriteReady during WAIT_RD and in IDLE -> ignored. Assert ARESET in WAIT_WR
//     -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ram_access_master.sv
// Ram bus initiator: takes one load/store at a time from the memory stage, issues a single-cycle
// Ram request, waits for the matching ready (or timeout) and returns a one-cycle response.
module ram_access_master #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [ADDR_W-1:0] ram_write_addr_o,
  output logic [DATA_W-1:0] ram_write_data_o,
  output logic [3:0]        ram_write_strb_o,
  output logic [ADDR_W-1:0] ram_read_addr_o,
  input  logic [DATA_W-1:0] ram_read_data_i,
  input  logic              ram_read_ready_i,
  input  logic              ram_write_ready_i
);

  typedef enum logic [2:0] {
    StIdle,
    StIssueRd,
    StIssueWr,
    StWaitRd,
    StWaitWr,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;

  logic [ADDR_W-1:0] ram_read_addr_d, ram_write_addr_d;
  logic [DATA_W-1:0] ram_write_data_d, rsp_rdata_d;
  logic [3:0]        ram_write_strb_d;
  logic              rsp_valid_d, rsp_err_d;
  logic              timeout_hit;

  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] sz);
    logic [DATA_W-1:0] m;
    case (sz)
      2'd0:    m = {{(DATA_W-8){1'b0}}, 8'hFF};
      2'd1:    m = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      2'd2:    m = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                    input logic [1:0] sz, input logic sgn);
    logic [DATA_W-1:0] m;
    logic              sign_bit;
    m = size_mask(sz);
    case (sz)
      2'd0:    sign_bit = raw[7];
      2'd1:    sign_bit = raw[15];
      2'd2:    sign_bit = raw[31];
      default: sign_bit = 1'b0;
    endcase
    sign_bit = sign_bit & sgn;
    return (raw & m) | ({DATA_W{sign_bit}} & ~m);
  endfunction

  // The count reaching TIMEOUT this cycle ends the wait unless the matching ready is also here.
  assign timeout_hit = ({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT);

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          size_d   = req_size_i;
          signed_d = req_signed_i;
          if (req_addr_i == '0) begin
            state_d = StResp;
          end else begin
            state_d = req_write_i ? StIssueWr : StIssueRd;
          end
        end
      end
      StIssueRd: state_d = StWaitRd;
      StIssueWr: state_d = StWaitWr;
      StWaitRd: begin
        cnt_d = cnt_q + 16'd1;
        if (ram_read_ready_i || timeout_hit) begin
          state_d = StResp;
          cnt_d   = '0;
        end
      end
      StWaitWr: begin
        cnt_d = cnt_q + 16'd1;
        if (ram_write_ready_i || timeout_hit) begin
          state_d = StResp;
          cnt_d   = '0;
        end
      end
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    ram_read_addr_d  = '0;
    ram_write_addr_d = '0;
    ram_write_data_d = '0;
    ram_write_strb_d = '0;
    rsp_valid_d      = 1'b0;
    rsp_err_d        = 1'b0;
    rsp_rdata_d      = '0;
    unique case (state_d)
      StIssueRd: ram_read_addr_d = addr_d;
      StIssueWr: begin
        ram_write_addr_d = addr_d;
        ram_write_strb_d = 4'b0001 << size_d;
        ram_write_data_d = wdata_d & size_mask(size_d);
      end
      StResp: begin
        rsp_valid_d = 1'b1;
        if (state_q == StWaitRd && ram_read_ready_i) begin
          rsp_rdata_d = load_extend(ram_read_data_i, size_q, signed_q);
        end else if (!(state_q == StWaitWr && ram_write_ready_i)) begin
          rsp_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      ram_read_addr_o  <= '0;
      ram_write_addr_o <= '0;
      ram_write_data_o <= '0;
      ram_write_strb_o <= '0;
      rsp_valid_o      <= 1'b0;
      rsp_err_o        <= 1'b0;
      rsp_rdata_o      <= '0;
    end else begin
      ram_read_addr_o  <= ram_read_addr_d;
      ram_write_addr_o <= ram_write_addr_d;
      ram_write_data_o <= ram_write_data_d;
      ram_write_strb_o <= ram_write_strb_d;
      rsp_valid_o      <= rsp_valid_d;
      rsp_err_o        <= rsp_err_d;
      rsp_rdata_o      <= rsp_rdata_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);

endmodule

// File: tb/tb_ram_access_master.sv
// Bench for ram_access_master: directed and random load/store transactions against a
// transaction-level model of latency, bus pulses and response data.
module tb_ram_access_master;

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [63:0] ram_write_addr, ram_write_data, ram_read_addr, ram_read_data;
  logic [3:0]  ram_write_strb;
  logic        ram_read_ready, ram_write_ready;

  int checks = 0;
  int failures = 0;

  ram_access_master #(
    .ADDR_W (64),
    .DATA_W (64),
    .TIMEOUT(8)
  ) dut (
    .aclk_i           (aclk),
    .areset_i         (areset),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_write_i      (req_write),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .req_size_i       (req_size),
    .req_signed_i     (req_signed),
    .rsp_valid_o      (rsp_valid),
    .rsp_err_o        (rsp_err),
    .rsp_rdata_o      (rsp_rdata),
    .ram_write_addr_o (ram_write_addr),
    .ram_write_data_o (ram_write_data),
    .ram_write_strb_o (ram_write_strb),
    .ram_read_addr_o  (ram_read_addr),
    .ram_read_data_i  (ram_read_data),
    .ram_read_ready_i (ram_read_ready),
    .ram_write_ready_i(ram_write_ready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_mask(input logic [1:0] size);
    int nbytes;
    nbytes = 1 << size;
    if (nbytes == 8) return '1;
    return (64'd1 << (8 * nbytes)) - 64'd1;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] raw, input logic [1:0] size,
                                             input logic sgn);
    logic [63:0] m, v;
    int          nbytes;
    nbytes = 1 << size;
    m = model_mask(size);
    v = raw & m;
    if (sgn && nbytes < 8 && v[8*nbytes-1]) v = v | ~m;
    return v;
  endfunction

  // d = wait cycle (1-based) in which the Ram pulses ready; 0 or beyond TIMEOUT means never.
  task automatic do_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic sgn, input int d,
                        input logic [63:0] raw);
    logic [3:0]  strb_tbl [4];
    int          rd_pulses, wr_pulses, lat, exp_lat;
    logic [63:0] seen_raddr, seen_waddr, seen_wdata, got_rdata, exp_rdata;
    logic [3:0]  seen_strb;
    logic        got, got_err, exp_err, ok_ready, zero;
    strb_tbl = '{4'h1, 4'h2, 4'h4, 4'h8};
    rd_pulses = 0; wr_pulses = 0; lat = 0; got = 0; got_err = 0; got_rdata = '0;
    seen_raddr = '0; seen_waddr = '0; seen_wdata = '0; seen_strb = '0;
    zero = (addr == 64'd0);
    ok_ready = (d >= 1 && d <= 8);

    @(negedge aclk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    req_size = size; req_signed = sgn;
    @(posedge aclk); #1;
    req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    for (int c = 1; c <= 20 && !got; c++) begin
      if (c > 1) begin
        @(posedge aclk); #1;
      end
      if (ram_read_addr != 64'd0) begin
        rd_pulses++; seen_raddr = ram_read_addr;
      end
      if (ram_write_addr != 64'd0) begin
        wr_pulses++; seen_waddr = ram_write_addr; seen_wdata = ram_write_data;
        seen_strb = ram_write_strb;
      end
      if (rsp_valid) begin
        got = 1'b1; lat = c; got_err = rsp_err; got_rdata = rsp_rdata;
      end
      ram_read_data = {$urandom, $urandom};
      if (c == 1) begin
        ram_read_ready = 1'b1; ram_write_ready = 1'b1;
      end else begin
        ram_read_ready  = wr ? (c == 2) : (c == d + 1);
        ram_write_ready = wr ? (c == d + 1) : (c == 2);
        if (!wr && c == d + 1) ram_read_data = raw;
      end
    end
    ram_read_ready = 1'b0; ram_write_ready = 1'b0;

    exp_lat   = zero ? 1 : (ok_ready ? d + 2 : 10);
    exp_err   = zero || !ok_ready;
    exp_rdata = (wr || exp_err) ? 64'd0 : model_load(raw, size, sgn);
    chk("rsp_seen", {63'd0, got}, 64'd1);
    chk("rsp_latency", 64'(lat), 64'(exp_lat));
    chk("rsp_err", {63'd0, got_err}, {63'd0, exp_err});
    chk("rsp_rdata", got_rdata, exp_rdata);
    chk("read_pulses", 64'(rd_pulses), (!zero && !wr) ? 64'd1 : 64'd0);
    chk("write_pulses", 64'(wr_pulses), (!zero && wr) ? 64'd1 : 64'd0);
    if (!zero && !wr) chk("read_addr", seen_raddr, addr);
    if (!zero && wr) begin
      chk("write_addr", seen_waddr, addr);
      chk("write_strb", {60'd0, seen_strb}, {60'd0, strb_tbl[size]});
      chk("write_data", seen_wdata, wdata & model_mask(size));
    end
    @(posedge aclk); #1;
    chk("rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);
    chk("req_ready_back", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    int seen_rsp;
    logic wr;
    logic [63:0] a;
    areset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_signed = 1'b0; ram_read_data = '0;
    ram_read_ready = 1'b0; ram_write_ready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_raddr", ram_read_addr, 64'd0);
    chk("reset_waddr", ram_write_addr, 64'd0);
    chk("reset_wstrb", {60'd0, ram_write_strb}, 64'd0);
    areset = 1'b0;
    @(posedge aclk); #1;

    // Directed cases from the block description.
    do_txn(1'b0, 64'h8000_0010, 64'd0, 2'd0, 1'b1, 3, 64'h1234_5678_9ABC_00F0);
    do_txn(1'b1, 64'h8000_0020, 64'h1234_ABCD, 2'd1, 1'b0, 2, 64'd0);
    do_txn(1'b0, 64'h8000_0030, 64'd0, 2'd2, 1'b0, 1, 64'hFFFF_FFFF_8000_0001);
    do_txn(1'b0, 64'h8000_0038, 64'd0, 2'd3, 1'b1, 4, 64'hF123_4567_89AB_CDEF);
    do_txn(1'b0, 64'd0, 64'd0, 2'd2, 1'b0, 2, 64'd0);
    do_txn(1'b1, 64'd0, 64'hFFFF, 2'd3, 1'b0, 2, 64'd0);
    do_txn(1'b0, 64'h8000_0040, 64'd0, 2'd1, 1'b1, 0, 64'd0);
    do_txn(1'b1, 64'h8000_0048, 64'h55, 2'd0, 1'b0, 0, 64'd0);
    do_txn(1'b0, 64'h8000_0050, 64'd0, 2'd1, 1'b1, 8, 64'h0000_0000_0000_8001);
    do_txn(1'b1, 64'h8000_0058, 64'hDEAD_BEEF_CAFE_F00D, 2'd3, 1'b0, 8, 64'd0);

    // Stray readies while idle must not produce a response.
    @(negedge aclk);
    ram_read_ready = 1'b1; ram_write_ready = 1'b1;
    @(posedge aclk); #1;
    ram_read_ready = 1'b0; ram_write_ready = 1'b0;
    @(posedge aclk); #1;
    chk("idle_stray_rsp", {63'd0, rsp_valid}, 64'd0);
    chk("idle_stray_ready", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 64'd0 : ({$urandom, $urandom} | 64'h8);
      do_txn(wr, a, {$urandom, $urandom}, 2'($urandom), 1'($urandom),
             $urandom_range(0, 10), {$urandom, $urandom});
    end

    // Reset while a store is waiting for the Ram.
    @(negedge aclk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h8000_0100; req_wdata = 64'h77;
    req_size = 2'd0;
    @(posedge aclk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("wait_wr_busy", {63'd0, req_ready}, 64'd0);
    areset = 1'b1;
    #1;
    chk("midreset_req_ready", {63'd0, req_ready}, 64'd1);
    chk("midreset_waddr", ram_write_addr, 64'd0);
    chk("midreset_rsp", {63'd0, rsp_valid}, 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    seen_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge aclk); #1;
      if (c == 0) ram_write_ready = 1'b1;
      else ram_write_ready = 1'b0;
      if (rsp_valid) seen_rsp++;
    end
    chk("no_rsp_after_reset", 64'(seen_rsp), 64'd0);
    do_txn(1'b0, 64'h8000_0200, 64'd0, 2'd1, 1'b0, 2, 64'h0000_0000_0000_FF80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
